lsu_sram_master: RTL and testbench
==================================

Name: lsu_sram_master

Overview:
- Data-side initiator for the core's synchronous single-port SRAM interface (sram_cen/sram_wen/sram_ben/sram_addr/sram_din/sram_dout).
- Accepts one load/store request at a time from the execute stage and issues one SRAM strobe per request.
- Builds per-byte-lane write data and enables, then aligns and sign- or zero-extends read data.
- Flags misaligned and out-of-range accesses without touching the SRAM.

Parameters:
- MEM_BYTES, 2**26, addressable data memory size in bytes. A request with addr >= MEM_BYTES is an access fault.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  load zero-extends (LBU/LHU); ignored for stores and word loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  32  load result; 0 for stores and faults.
- rsp_err  output  1  qualifies rsp_valid: misaligned, illegal size or out-of-range.
- sram_cen  output  1  active-low chip enable.
- sram_wen  output  1  active-low write enable.
- sram_ben  output  4  active-low byte enables; bit i = byte lane i (bits 8i+7:8i).
- sram_addr  output  32  word address, bits [1:0] always 0.
- sram_din  output  32  write data.
- sram_dout  input  32  read data, valid one cycle after the strobe cycle.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = IDLE; sram_cen = 1, sram_wen = 1, sram_ben = 4'hF, sram_addr = 0, sram_din = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready = 1, decoded from IDLE.
- All sram_* outputs and rsp_* outputs except load rsp_rdata are registered.
- States: IDLE, ACCESS, RDWAIT, FAULT.
- IDLE: on req_valid && req_ready (cycle N), check the request:
  - Fault if any of: req_size = 11; size 01 and addr[0] = 1; size 10 and addr[1:0] != 0; addr >= MEM_BYTES.
  - Fault → FAULT. Otherwise → ACCESS.
  - Latch offset = addr[1:0], size, unsigned and we.
  - Register the strobe for cycle N+1: sram_cen = 0, sram_wen = ~we, sram_addr = {addr[31:2], 2'b00}.
- Store lane and data rules:
  - Byte: sram_din = {4{wdata[7:0]}}, sram_ben = ~(4'b0001 << offset).
  - Half: sram_din = {2{wdata[15:0]}}, sram_ben = offset[1] ? 4'b0011 : 4'b1100.
  - Word: sram_din = wdata, sram_ben = 4'h0.
  - Loads drive sram_ben = 4'h0.
- ACCESS (cycle N+1, strobe visible):
  - Store: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0 in N+1 → IDLE.
  - Load → RDWAIT.
  - Strobe deasserts at the next edge (cen = wen = 1, ben = F). sram_addr/sram_din hold.
- RDWAIT (cycle N+2): rsp_valid = 1, rsp_err = 0, and rsp_rdata is combinational from sram_dout:
  - shifted = sram_dout >> (8*offset).
  - Byte: extend shifted[7:0]. Half: extend shifted[15:0]. Word: sram_dout.
  - Sign-extend unless unsigned.
  - → IDLE.
- FAULT (cycle N+1): rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, no SRAM strobe → IDLE.
- req_ready = 0 in ACCESS/RDWAIT/FAULT; requests presented then are not accepted and must be held.
- Throughput: store/fault every 2 cycles, load every 3 cycles. A request presented in the rsp_valid cycle is accepted the following cycle.
- Reset mid-operation: any state → IDLE immediately, strobe removed asynchronously, no rsp_valid for the aborted request.
- Exactly one rsp_valid pulse per accepted request; never two strobes per request.
- Address compare is unsigned 32-bit; wrap-around is not possible.

Test Plan:
- Word store then load:
  - Store addr 0x100, wdata 0xDEADBEEF → in N+1 sram_cen = 0, wen = 0, ben = 0000, addr = 0x100, rsp_valid = 1.
  - Load addr 0x100 → rsp_valid in N+2, rsp_rdata = 0xDEADBEEF.
- Byte lanes:
  - Store byte 0xA5 at 0x203 → ben = 0111, din = 0xA5A5A5A5.
  - LB at 0x203 → 0xFFFFFFA5. LBU → 0x000000A5. LB at 0x200 returns the untouched lane.
- Halfword:
  - Store 0x8001 at 0x302 → ben = 0011, din = 0x80018001.
  - LH at 0x302 → 0xFFFF8001. LHU → 0x00008001.
- Faults:
  - LW at 0x102, SH at 0x101, size 11, and LW at 0x04000000 (default MEM_BYTES) → rsp_valid/rsp_err = 1 in N+1, rdata 0, sram_cen stays 1 throughout.
- Handshake: req_valid held high across back-to-back loads → req_ready low for 2 cycles after each accept, exactly one strobe and one rsp per load.
- Reset: rst_n low in the cycle after a load is accepted → sram_cen = 1 immediately, no rsp_valid, req_ready = 1, next request serviced normally.

Source files
------------

// File: rtl/lsu_sram_master.sv
// Data-side load/store initiator for a synchronous single-port SRAM.
// One request in flight: builds lane enables/data for stores, aligns and extends load data.
module lsu_sram_master #(
  parameter logic [32:0] MEM_BYTES = 33'h0_0400_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_sram_cen,
  output logic        o_sram_wen,
  output logic [3:0]  o_sram_ben,
  output logic [31:0] o_sram_addr,
  output logic [31:0] o_sram_din,
  input  logic [31:0] i_sram_dout
);

  localparam int unsigned DW = 32;
  localparam int unsigned LANES = DW / 8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RDWAIT, S_FAULT} state_t;

  state_t             r_state;
  logic               r_ready;
  logic               r_rsp_valid;
  logic               r_rsp_err;
  logic               r_cen;
  logic               r_wen;
  logic [LANES-1:0]   r_ben;
  logic [DW-1:0]      r_addr;
  logic [DW-1:0]      r_din;
  logic [1:0]         r_off;
  logic [1:0]         r_size;
  logic               r_uns;
  logic               r_we;

  logic               w_fault;
  logic [LANES-1:0]   w_st_ben;
  logic [DW-1:0]      w_st_din;
  logic [15:0]        w_lo;
  logic [DW-1:0]      w_rdata;

  // Request decode: fault detection and store lane/data replication
  always_comb begin
    w_fault = (i_req_size == 2'b11)
            | ((i_req_size == 2'b01) & i_req_addr[0])
            | ((i_req_size == 2'b10) & (|i_req_addr[1:0]))
            | ({1'b0, i_req_addr} >= MEM_BYTES);
    w_st_ben = '0;
    w_st_din = i_req_wdata;
    case (i_req_size)
      2'b00: begin
        w_st_din = {4{i_req_wdata[7:0]}};
        w_st_ben = ~(4'b0001 << i_req_addr[1:0]);
      end
      2'b01: begin
        w_st_din = {2{i_req_wdata[15:0]}};
        w_st_ben = i_req_addr[1] ? 4'b0011 : 4'b1100;
      end
      default: ;
    endcase
  end

  // Load alignment and extension, combinational from the SRAM read port
  always_comb begin
    w_lo    = 16'(i_sram_dout >> {r_off, 3'b000});
    w_rdata = '0;
    if (r_state == S_RDWAIT) begin
      case (r_size)
        2'b00:   w_rdata = {{24{~r_uns & w_lo[7]}}, w_lo[7:0]};
        2'b01:   w_rdata = {{16{~r_uns & w_lo[15]}}, w_lo[15:0]};
        default: w_rdata = i_sram_dout;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_cen       <= 1'b1;
      r_wen       <= 1'b1;
      r_ben       <= '1;
      r_addr      <= '0;
      r_din       <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_uns       <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_off   <= i_req_addr[1:0];
            r_size  <= i_req_size;
            r_uns   <= i_req_unsigned;
            r_we    <= i_req_we;
            r_ready <= 1'b0;
            if (w_fault) begin
              r_state     <= S_FAULT;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else begin
              r_state <= S_ACCESS;
              r_cen   <= 1'b0;
              r_wen   <= ~i_req_we;
              r_addr  <= {i_req_addr[31:2], 2'b00};
              r_ben   <= i_req_we ? w_st_ben : '0;
              if (i_req_we) begin
                r_din       <= w_st_din;
                r_rsp_valid <= 1'b1;
              end
            end
          end
        end
        S_ACCESS: begin
          r_cen <= 1'b1;
          r_wen <= 1'b1;
          r_ben <= '1;
          if (r_we) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_state     <= S_RDWAIT;
            r_rsp_valid <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready = r_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = w_rdata;
  assign o_sram_cen  = r_cen;
  assign o_sram_wen  = r_wen;
  assign o_sram_ben  = r_ben;
  assign o_sram_addr = r_addr;
  assign o_sram_din  = r_din;

endmodule

// File: tb/tb_lsu_sram_master.sv
// Self-checking bench for lsu_sram_master: SRAM model plus byte-level reference memory.
module tb_lsu_sram_master;

  logic        clk;
  logic        rst_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_sram_cen;
  logic        o_sram_wen;
  logic [3:0]  o_sram_ben;
  logic [31:0] o_sram_addr;
  logic [31:0] o_sram_din;
  logic [31:0] i_sram_dout;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  int rsp_cnt = 0;

  logic [31:0] sram_mem [int unsigned];
  logic [7:0]  model_mem [int unsigned];
  logic [31:0] sram_w;

  // Results of the most recent run_req
  int          res_lat, res_nstb, res_nrsp;
  logic [31:0] res_rdata, res_addr, res_din;
  logic        res_err, res_wen;
  logic [3:0]  res_ben;

  lsu_sram_master dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_we(i_req_we),
    .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err(o_rsp_err), .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen),
    .o_sram_ben(o_sram_ben), .o_sram_addr(o_sram_addr), .o_sram_din(o_sram_din),
    .i_sram_dout(i_sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM with one-cycle read latency, plus strobe/response counters
  always @(posedge clk) begin
    if (o_rsp_valid) rsp_cnt <= rsp_cnt + 1;
    if (!o_sram_cen) begin
      strobe_cnt <= strobe_cnt + 1;
      if (!o_sram_wen) begin
        sram_w = sram_mem.exists(o_sram_addr >> 2) ? sram_mem[o_sram_addr >> 2] : 32'h0;
        for (int i = 0; i < 4; i++)
          if (!o_sram_ben[i]) sram_w[8*i +: 8] = o_sram_din[8*i +: 8];
        sram_mem[o_sram_addr >> 2] = sram_w;
      end else begin
        i_sram_dout <= sram_mem.exists(o_sram_addr >> 2) ? sram_mem[o_sram_addr >> 2] : 32'h0;
      end
    end
  end

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  function automatic logic exp_fault(input logic [1:0] s, input logic [31:0] a);
    return (s == 2'd3) || ((a % nbytes(s)) != 0) || (a >= 32'h0400_0000);
  endfunction

  // Little-endian assembly of n bytes, then two's-complement reinterpretation
  function automatic logic [31:0] exp_load(input logic [1:0] s, input logic u, input logic [31:0] a);
    longint v = 0;
    int n = nbytes(s);
    for (int i = 0; i < n; i++) v += longint'(mbyte(a + i)) << (8 * i);
    if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic model_store(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(s); i++) model_mem[a + i] = d[8*i +: 8];
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    res_lat = -1; res_rdata = '0; res_err = 1'b0; res_nstb = 0; res_nrsp = 0;
    res_addr = '0; res_din = '0; res_ben = 4'hF; res_wen = 1'b1;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size;
    i_req_unsigned = uns; i_req_addr = addr; i_req_wdata = wdata;
    for (int n = 0; n < 20 && !o_req_ready; n++) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      i_req_valid = 1'b0;
      if (!o_sram_cen) begin
        res_nstb++;
        if (res_nstb == 1) begin
          res_addr = o_sram_addr; res_din = o_sram_din; res_ben = o_sram_ben; res_wen = o_sram_wen;
        end
      end
      if (o_rsp_valid) begin
        res_nrsp++;
        if (res_lat < 0) begin res_lat = k; res_rdata = o_rsp_rdata; res_err = o_rsp_err; end
      end
    end
    if (we && !exp_fault(size, addr)) model_store(size, addr, wdata);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_sram_cen !== 1'b1) begin failures++; $display("FAIL rst_cen got=%b exp=1", o_sram_cen); end
    checks++; if (o_sram_wen !== 1'b1) begin failures++; $display("FAIL rst_wen got=%b exp=1", o_sram_wen); end
    checks++; if (o_sram_ben !== 4'hF) begin failures++; $display("FAIL rst_ben got=%h exp=f", o_sram_ben); end
    checks++; if (o_sram_addr !== 32'h0 || o_sram_din !== 32'h0) begin failures++; $display("FAIL rst_addr_din got=%h/%h exp=0/0", o_sram_addr, o_sram_din); end
    checks++; if (o_rsp_valid !== 1'b0 || o_rsp_err !== 1'b0 || o_rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp got=%b/%b/%h exp=0/0/0", o_rsp_valid, o_rsp_err, o_rsp_rdata); end
    checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", o_req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word();
    run_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    checks++; if (res_lat !== 1 || res_err !== 1'b0) begin failures++; $display("FAIL sw_rsp got lat=%0d err=%b exp lat=1 err=0", res_lat, res_err); end
    checks++; if (res_nstb !== 1 || res_wen !== 1'b0 || res_ben !== 4'h0) begin failures++; $display("FAIL sw_strobe got n=%0d wen=%b ben=%h exp n=1 wen=0 ben=0", res_nstb, res_wen, res_ben); end
    checks++; if (res_addr !== 32'h100 || res_din !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_addr_din got=%h/%h exp=100/deadbeef", res_addr, res_din); end
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    checks++; if (res_lat !== 2 || res_err !== 1'b0 || res_nrsp !== 1) begin failures++; $display("FAIL lw_rsp got lat=%0d err=%b n=%0d exp lat=2 err=0 n=1", res_lat, res_err, res_nrsp); end
    checks++; if (res_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", res_rdata); end
    checks++; if (res_nstb !== 1 || res_wen !== 1'b1 || res_ben !== 4'h0) begin failures++; $display("FAIL lw_strobe got n=%0d wen=%b ben=%h exp n=1 wen=1 ben=0", res_nstb, res_wen, res_ben); end
  endtask

  task automatic test_bytes();
    run_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h11223344);
    run_req(1'b1, 2'd0, 1'b0, 32'h203, 32'h000000A5);
    checks++; if (res_ben !== 4'b0111 || res_din !== 32'hA5A5A5A5) begin failures++; $display("FAIL sb_lanes got ben=%b din=%h exp ben=0111 din=a5a5a5a5", res_ben, res_din); end
    run_req(1'b0, 2'd0, 1'b0, 32'h203, 32'h0);
    checks++; if (res_rdata !== 32'hFFFFFFA5) begin failures++; $display("FAIL lb_sext got=%h exp=ffffffa5", res_rdata); end
    run_req(1'b0, 2'd0, 1'b1, 32'h203, 32'h0);
    checks++; if (res_rdata !== 32'h000000A5) begin failures++; $display("FAIL lbu got=%h exp=000000a5", res_rdata); end
    run_req(1'b0, 2'd0, 1'b0, 32'h200, 32'h0);
    checks++; if (res_rdata !== 32'h00000044) begin failures++; $display("FAIL lb_lane0 got=%h exp=00000044", res_rdata); end
    run_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    checks++; if (res_rdata !== 32'hA5223344) begin failures++; $display("FAIL lw_merged got=%h exp=a5223344", res_rdata); end
  endtask

  task automatic test_half();
    run_req(1'b1, 2'd1, 1'b0, 32'h302, 32'h12348001);
    checks++; if (res_ben !== 4'b0011 || res_din !== 32'h80018001) begin failures++; $display("FAIL sh_hi got ben=%b din=%h exp ben=0011 din=80018001", res_ben, res_din); end
    run_req(1'b1, 2'd1, 1'b0, 32'h300, 32'h00007F55);
    checks++; if (res_ben !== 4'b1100) begin failures++; $display("FAIL sh_lo got ben=%b exp=1100", res_ben); end
    run_req(1'b0, 2'd1, 1'b0, 32'h302, 32'h0);
    checks++; if (res_rdata !== 32'hFFFF8001) begin failures++; $display("FAIL lh_sext got=%h exp=ffff8001", res_rdata); end
    run_req(1'b0, 2'd1, 1'b1, 32'h302, 32'h0);
    checks++; if (res_rdata !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h exp=00008001", res_rdata); end
    run_req(1'b0, 2'd1, 1'b0, 32'h300, 32'h0);
    checks++; if (res_rdata !== 32'h00007F55) begin failures++; $display("FAIL lh_pos got=%h exp=00007f55", res_rdata); end
  endtask

  task automatic test_faults();
    logic        f_we   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [1:0]  f_size [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd0};
    logic [31:0] f_addr [5] = '{32'h102, 32'h101, 32'h100, 32'h0400_0000, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      run_req(f_we[i], f_size[i], 1'b0, f_addr[i], 32'hCAFEF00D);
      checks++;
      if (res_lat !== 1 || res_err !== 1'b1 || res_rdata !== 32'h0 || res_nstb !== 0 || res_nrsp !== 1) begin
        failures++;
        $display("FAIL fault_%0d got lat=%0d err=%b rdata=%h strobes=%0d rsps=%0d exp lat=1 err=1 rdata=0 strobes=0 rsps=1",
                 i, res_lat, res_err, res_rdata, res_nstb, res_nrsp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h100, 32'h200, 32'h300};
    logic [31:0] expv  [3];
    int acc = 0, low_run = 0, rsp_seen = 0, s0, r0;
    logic pend = 1'b0;
    for (int i = 0; i < 3; i++) expv[i] = exp_load(2'd2, 1'b0, addrs[i]);
    @(negedge clk);
    s0 = strobe_cnt; r0 = rsp_cnt;
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_unsigned = 1'b0; i_req_addr = addrs[0];
    for (int cyc = 0; cyc < 30 && rsp_seen < 3; cyc++) begin
      if (pend) begin
        if (acc < 3) i_req_addr = addrs[acc]; else i_req_valid = 1'b0;
        pend = 1'b0;
      end
      if (o_rsp_valid) begin
        checks++; if (o_rsp_rdata !== expv[rsp_seen]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", rsp_seen, o_rsp_rdata, expv[rsp_seen]); end
        rsp_seen++;
      end
      if (i_req_valid && o_req_ready) begin
        if (acc > 0) begin
          checks++; if (low_run !== 2) begin failures++; $display("FAIL b2b_ready_low%0d got=%0d exp=2", acc, low_run); end
        end
        acc++; low_run = 0; pend = 1'b1;
      end else if (!o_req_ready) begin
        low_run++;
      end
      @(negedge clk);
    end
    i_req_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rsp_seen !== 3 || acc !== 3) begin failures++; $display("FAIL b2b_count got acc=%0d rsp=%0d exp 3/3", acc, rsp_seen); end
    checks++; if (strobe_cnt - s0 !== 3 || rsp_cnt - r0 !== 3) begin failures++; $display("FAIL b2b_pulses got strobes=%0d rsps=%0d exp 3/3", strobe_cnt - s0, rsp_cnt - r0); end
  endtask

  task automatic test_reset_mid();
    int r0;
    @(negedge clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_unsigned = 1'b0; i_req_addr = 32'h100;
    for (int n = 0; n < 20 && !o_req_ready; n++) @(negedge clk);
    @(negedge clk);
    i_req_valid = 1'b0;
    r0 = rsp_cnt;
    checks++; if (o_sram_cen !== 1'b0) begin failures++; $display("FAIL rm_strobe got cen=%b exp=0", o_sram_cen); end
    rst_n = 1'b0;
    #1;
    checks++; if (o_sram_cen !== 1'b1 || o_sram_ben !== 4'hF || o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
      failures++; $display("FAIL rm_abort got cen=%b ben=%h rsp=%b ready=%b exp 1/f/0/1", o_sram_cen, o_sram_ben, o_rsp_valid, o_req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rsp_cnt !== r0) begin failures++; $display("FAIL rm_no_rsp got=%0d exp=%0d", rsp_cnt, r0); end
    run_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    checks++; if (res_lat !== 2 || res_rdata !== exp_load(2'd2, 1'b0, 32'h100)) begin failures++; $display("FAIL rm_after got lat=%0d data=%h exp lat=2 data=%h", res_lat, res_rdata, exp_load(2'd2, 1'b0, 32'h100)); end
  endtask

  task automatic test_random();
    logic        we, uns, flt;
    logic [1:0]  size;
    logic [31:0] addr, wdata, ebits, mask, edata;
    int off, n;
    for (int it = 0; it < 60; it++) begin
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3)); wdata = $urandom;
      case ($urandom_range(0, 9))
        0:       addr = 32'h0400_0000 + 32'($urandom_range(0, 255));
        1:       addr = 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
        default: addr = 32'h400 + 32'($urandom_range(0, 63));
      endcase
      flt = exp_fault(size, addr);
      edata = exp_load(size, uns, addr);
      run_req(we, size, uns, addr, wdata);
      checks++;
      if (flt) begin
        if (res_lat !== 1 || res_err !== 1'b1 || res_rdata !== 32'h0 || res_nstb !== 0 || res_nrsp !== 1) begin
          failures++; $display("FAIL rnd%0d_fault got lat=%0d err=%b data=%h strobes=%0d exp 1/1/0/0", it, res_lat, res_err, res_rdata, res_nstb);
        end
      end else if (we) begin
        off = int'(addr[1:0]); n = nbytes(size); ebits = '0; mask = '0;
        for (int i = 0; i < n; i++) begin
          mask[8*(off+i) +: 8] = 8'hFF;
          ebits[8*(off+i) +: 8] = wdata[8*i +: 8];
        end
        if (res_lat !== 1 || res_err !== 1'b0 || res_nstb !== 1 || res_wen !== 1'b0 ||
            res_addr !== {addr[31:2], 2'b00} || (res_din & mask) !== ebits ||
            res_ben !== ~{mask[24], mask[16], mask[8], mask[0]}) begin
          failures++; $display("FAIL rnd%0d_store got lat=%0d addr=%h din=%h ben=%b exp lat=1 addr=%h din&m=%h ben=%b",
                               it, res_lat, res_addr, res_din, res_ben, {addr[31:2], 2'b00}, ebits, ~{mask[24], mask[16], mask[8], mask[0]});
        end
      end else begin
        if (res_lat !== 2 || res_err !== 1'b0 || res_nstb !== 1 || res_ben !== 4'h0 || res_rdata !== edata) begin
          failures++; $display("FAIL rnd%0d_load got lat=%0d data=%h ben=%h strobes=%0d exp lat=2 data=%h ben=0 strobes=1",
                               it, res_lat, res_rdata, res_ben, res_nstb, edata);
        end
      end
    end
  endtask

  initial begin
    i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0; i_req_unsigned = 1'b0;
    i_req_addr = '0; i_req_wdata = '0; i_sram_dout = '0;
    test_reset();
    test_word();
    test_bytes();
    test_half();
    test_faults();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
